traffic_lamp_monitor: RTL and testbench

TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

---
 rtl/traffic_lamp_monitor.sv | 198 +++++++++++++++++++
 tb/tb_traffic_lamp_monitor.sv | 132 +++++++++++++
 2 files changed

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor
//   Watches an upstream traffic-light phase code and re-drives the three lamps.
//   Phase code: 00 RED, 01 GREEN, 10 YELLOW, 11 illegal.
//   Any illegal code, out-of-order phase or stuck phase latches FAULT.
//   While in FAULT the red lamp flashes until fault_clr is raised.
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   light_in[1:0]   upstream phase code
//   fault_clr       level request to leave FAULT
//   lamp_*          lamp drives (registered)
//   fault           high while in FAULT
//   fault_code[1:0] 00 none, 01 ILLEGAL, 10 SEQ, 11 STUCK
//   cycle_cnt       completed RED-GREEN-YELLOW-RED cycles, saturating
module traffic_lamp_monitor #(
  parameter int FLASH_DIV   = 4,
  parameter int WDOG_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       light_in,
  input  logic             fault_clr,
  output logic             lamp_red,
  output logic             lamp_yellow,
  output logic             lamp_green,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int FL_W = $clog2(FLASH_DIV + 1);
  localparam int WD_W = $clog2(WDOG_CYCLES);

  localparam logic [1:0] C_RED = 2'b00;
  localparam logic [1:0] C_GRN = 2'b01;
  localparam logic [1:0] C_YEL = 2'b10;
  localparam logic [1:0] C_ILL = 2'b11;

  localparam logic [1:0] F_NONE  = 2'b00;
  localparam logic [1:0] F_ILL   = 2'b01;
  localparam logic [1:0] F_SEQ   = 2'b10;
  localparam logic [1:0] F_STUCK = 2'b11;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

  state_t           r_state, w_state;
  logic [1:0]       r_prev, w_prev;
  logic [WD_W-1:0]  r_wdog, w_wdog;
  logic [FL_W-1:0]  r_flash, w_flash;
  logic             r_red, w_red;
  logic             r_yel, w_yel;
  logic             r_grn, w_grn;
  logic             r_fault, w_fault;
  logic [1:0]       r_code, w_code;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [1:0]       w_succ;

  // Expected next phase after the last accepted one.
  always_comb begin
    case (r_prev)
      C_RED:   w_succ = C_GRN;
      C_GRN:   w_succ = C_YEL;
      C_YEL:   w_succ = C_RED;
      default: w_succ = C_RED;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_prev  = r_prev;
    w_wdog  = r_wdog;
    w_flash = r_flash;
    w_red   = r_red;
    w_yel   = r_yel;
    w_grn   = r_grn;
    w_fault = r_fault;
    w_code  = r_code;
    w_cnt   = r_cnt;

    case (r_state)
      S_INIT: begin
        w_red = 1'b1;
        w_yel = 1'b0;
        w_grn = 1'b0;
        if (light_in == C_RED) begin
          w_state = S_RUN;
          w_prev  = C_RED;
          w_wdog  = '0;
        end else if (light_in == C_ILL) begin
          w_state = S_FAULT;
          w_fault = 1'b1;
          w_code  = F_ILL;
          w_flash = '0;
        end
      end

      S_RUN: begin
        // Checks are ordered ILLEGAL, hold/STUCK, successor, SEQ so that at
        // most one fault can fire per cycle.
        if (light_in == C_ILL) begin
          w_state = S_FAULT;
          w_fault = 1'b1;
          w_code  = F_ILL;
        end else if (light_in == r_prev) begin
          if (r_wdog == WD_W'(WDOG_CYCLES - 1)) begin
            w_state = S_FAULT;
            w_fault = 1'b1;
            w_code  = F_STUCK;
          end else begin
            w_wdog = r_wdog + WD_W'(1);
          end
        end else if (light_in == w_succ) begin
          w_prev = light_in;
          w_wdog = '0;
          w_red  = (light_in == C_RED);
          w_grn  = (light_in == C_GRN);
          w_yel  = (light_in == C_YEL);
          if (r_prev == C_YEL && r_cnt != '1)
            w_cnt = r_cnt + CNT_W'(1);
        end else begin
          w_state = S_FAULT;
          w_fault = 1'b1;
          w_code  = F_SEQ;
        end
        // Entering FAULT starts the flash in its on-phase.
        if (w_state == S_FAULT) begin
          w_red   = 1'b1;
          w_yel   = 1'b0;
          w_grn   = 1'b0;
          w_flash = '0;
          w_wdog  = '0;
        end
      end

      S_FAULT: begin
        w_yel = 1'b0;
        w_grn = 1'b0;
        if (fault_clr) begin
          w_state = S_INIT;
          w_fault = 1'b0;
          w_code  = F_NONE;
          w_red   = 1'b1;
          w_flash = '0;
          w_wdog  = '0;
          w_prev  = C_RED;
        end else if (r_flash == FL_W'(FLASH_DIV - 1)) begin
          w_flash = '0;
          w_red   = ~r_red;
        end else begin
          w_flash = r_flash + FL_W'(1);
        end
      end

      default: begin
        w_state = S_INIT;
        w_red   = 1'b1;
        w_yel   = 1'b0;
        w_grn   = 1'b0;
        w_fault = 1'b0;
        w_code  = F_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
      r_prev  <= C_RED;
      r_wdog  <= '0;
      r_flash <= '0;
      r_red   <= 1'b1;
      r_yel   <= 1'b0;
      r_grn   <= 1'b0;
      r_fault <= 1'b0;
      r_code  <= F_NONE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_prev  <= w_prev;
      r_wdog  <= w_wdog;
      r_flash <= w_flash;
      r_red   <= w_red;
      r_yel   <= w_yel;
      r_grn   <= w_grn;
      r_fault <= w_fault;
      r_code  <= w_code;
      r_cnt   <= w_cnt;
    end
  end

  assign lamp_red    = r_red;
  assign lamp_yellow = r_yel;
  assign lamp_green  = r_grn;
  assign fault       = r_fault;
  assign fault_code  = r_code;
  assign cycle_cnt   = r_cnt;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor (FLASH_DIV=4, WDOG_CYCLES=16,
// CNT_W=2). Observed vector is {red, yellow, green, fault, code[1:0], cnt[1:0]}.
module tb_traffic_lamp_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] light_in;
  logic       fault_clr;
  logic       lamp_red, lamp_yellow, lamp_green, fault;
  logic [1:0] fault_code;
  logic [1:0] cycle_cnt;
  logic [7:0] w_obs;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [1:0] RED = 2'b00, GRN = 2'b01, YEL = 2'b10, ILL = 2'b11;

  traffic_lamp_monitor #(.FLASH_DIV(4), .WDOG_CYCLES(16), .CNT_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .light_in   (light_in),
    .fault_clr  (fault_clr),
    .lamp_red   (lamp_red),
    .lamp_yellow(lamp_yellow),
    .lamp_green (lamp_green),
    .fault      (fault),
    .fault_code (fault_code),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  assign w_obs = {lamp_red, lamp_yellow, lamp_green, fault, fault_code, cycle_cnt};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Apply one code, advance one rising edge, settle past the edge.
  task automatic step(input logic [1:0] li);
    light_in = li;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; fault_clr = 1'b0; light_in = RED;
    step(RED);
    chk("reset", w_obs, 8'b100_0_00_00);
    reset = 1'b0;

    // Two full cycles
    step(RED); chk("c1_red", w_obs, 8'b100_0_00_00);
    step(GRN); chk("c1_grn", w_obs, 8'b001_0_00_00);
    step(YEL); chk("c1_yel", w_obs, 8'b010_0_00_00);
    step(RED); chk("c1_end", w_obs, 8'b100_0_00_01);
    step(GRN); chk("c2_grn", w_obs, 8'b001_0_00_01);
    step(YEL); chk("c2_yel", w_obs, 8'b010_0_00_01);
    step(RED); chk("c2_end", w_obs, 8'b100_0_00_10);

    // GREEN -> RED is out of order; then the flash pattern 1111 0000 1111
    step(GRN); chk("pre_seq", w_obs, 8'b001_0_00_10);
    step(RED); chk("seq_entry", w_obs, 8'b100_1_10_10);
    for (int i = 1; i < 12; i++) begin
      logic r;
      r = ((i / 4) % 2) == 0;
      step(ILL);
      chk($sformatf("flash%0d", i), w_obs, {r, 7'b00_1_10_10});
    end

    // Clear back to INIT; GREEN/YELLOW hold INIT; fault_clr ignored in RUN
    fault_clr = 1'b1;
    step(YEL); chk("clr_seq", w_obs, 8'b100_0_00_10);
    fault_clr = 1'b0;
    step(YEL); chk("init_hold", w_obs, 8'b100_0_00_10);
    step(RED); chk("init_run", w_obs, 8'b100_0_00_10);
    fault_clr = 1'b1;
    step(RED); chk("clr_in_run", w_obs, 8'b100_0_00_10);
    fault_clr = 1'b0;

    // Illegal code from RUN, then clear keeps cycle_cnt
    step(ILL); chk("illegal", w_obs, 8'b100_1_01_10);
    fault_clr = 1'b1;
    step(ILL); chk("clr_ill", w_obs, 8'b100_0_00_10);
    fault_clr = 1'b0;

    // Watchdog: 15 holds then advance is fine
    step(RED); chk("wd_enter", w_obs, 8'b100_0_00_10);
    for (int i = 1; i <= 15; i++) begin
      step(RED);
      chk($sformatf("wd_hold%0d", i), w_obs, 8'b100_0_00_10);
    end
    step(GRN); chk("wd15_grn", w_obs, 8'b001_0_00_10);
    step(YEL); chk("wd_yel", w_obs, 8'b010_0_00_10);
    step(RED); chk("c3_end", w_obs, 8'b100_0_00_11);
    // 16th hold after the last transition trips STUCK
    for (int i = 1; i <= 15; i++) begin
      step(RED);
      chk($sformatf("st_hold%0d", i), w_obs, 8'b100_0_00_11);
    end
    step(RED); chk("stuck", w_obs, 8'b100_1_11_11);

    // Saturation: two more completed cycles keep cycle_cnt at 3
    fault_clr = 1'b1;
    step(RED); chk("clr_stuck", w_obs, 8'b100_0_00_11);
    fault_clr = 1'b0;
    step(RED);
    for (int k = 0; k < 2; k++) begin
      step(GRN); chk($sformatf("sat_grn%0d", k), w_obs, 8'b001_0_00_11);
      step(YEL); chk($sformatf("sat_yel%0d", k), w_obs, 8'b010_0_00_11);
      step(RED); chk($sformatf("sat_end%0d", k), w_obs, 8'b100_0_00_11);
    end

    // Reset beats fault_clr and light_in mid-FAULT
    step(ILL); chk("ill2", w_obs, 8'b100_1_01_11);
    reset = 1'b1; fault_clr = 1'b1;
    step(GRN); chk("rst_fault", w_obs, 8'b100_0_00_00);
    reset = 1'b0; fault_clr = 1'b0;
    step(GRN); chk("post_rst_init", w_obs, 8'b100_0_00_00);
    step(RED); chk("post_rst_run", w_obs, 8'b100_0_00_00);
    step(GRN); chk("post_rst_grn", w_obs, 8'b001_0_00_00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
